// File: rtl/vending_machine_gen_if.sv
// Coin/cancel inputs, dispense pulse and the change-nickel valid/ready port of the vending controller.
// The purchaser side drives coins and consumes change; the controller side owns credit and handshakes.
interface vending_machine_gen_if #(
    parameter int CREDIT_W = 5
);
    logic                io_nickel;
    logic                io_dime;
    logic                io_quarter;
    logic                io_cancel;
    logic                io_valid;
    logic                io_coin_reject;
    logic                io_change_valid;
    logic                io_change_ready;
    logic [CREDIT_W-1:0] io_credit;
    logic                io_busy;

    modport master (
        output io_nickel, io_dime, io_quarter, io_cancel, io_change_ready,
        input  io_valid, io_coin_reject, io_change_valid, io_credit, io_busy
    );

    modport slave (
        input  io_nickel, io_dime, io_quarter, io_cancel, io_change_ready,
        output io_valid, io_coin_reject, io_change_valid, io_credit, io_busy
    );
endinterface

// File: rtl/vending_machine_gen.sv
// Vending controller: accumulates credit in nickels, dispenses at PRICE, then pays change
// one nickel per valid/ready handshake. Cancel in COLLECT refunds the whole credit the same way.
module vending_machine_gen #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    vending_machine_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                valid_reg, change_valid_reg, busy_reg;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_any, coin_multi, accepting;

    // Only one coin value is taken per cycle; quarter wins over dime wins over nickel.
    always_comb begin
        coin_val = '0;
        if (bus.io_quarter)
            coin_val = (CREDIT_W+1)'(5);
        else if (bus.io_dime)
            coin_val = (CREDIT_W+1)'(2);
        else if (bus.io_nickel)
            coin_val = (CREDIT_W+1)'(1);
    end

    assign coin_any   = bus.io_nickel | bus.io_dime | bus.io_quarter;
    assign coin_multi = (bus.io_nickel & bus.io_dime) | (bus.io_nickel & bus.io_quarter) |
                        (bus.io_dime & bus.io_quarter);
    assign accepting  = (state_reg == IDLE) || (state_reg == COLLECT && !bus.io_cancel);
    assign sum        = {1'b0, credit_reg} + coin_val;

    // Held low during reset so no output toggles while the machine is being cleared.
    assign bus.io_coin_reject = reset & (accepting ? coin_multi : coin_any);

    always_comb begin
        state_next  = state_reg;
        credit_next = credit_reg;
        case (state_reg)
            IDLE, COLLECT: begin
                if (state_reg == COLLECT && bus.io_cancel) begin
                    state_next = CHANGE;
                end else if (coin_any) begin
                    credit_next = sum[CREDIT_W-1:0];
                    state_next  = (sum >= PRICE_EXT) ? VEND : COLLECT;
                end
            end
            VEND: begin
                credit_next = credit_reg - PRICE_C;
                state_next  = (credit_reg > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (bus.io_change_ready) begin
                    credit_next = credit_reg - ONE;
                    if (credit_reg == ONE)
                        state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            valid_reg        <= 1'b0;
            change_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            valid_reg        <= (state_next == VEND);
            change_valid_reg <= (state_next == CHANGE);
            busy_reg         <= (state_next == VEND) || (state_next == CHANGE);
        end
    end

    assign bus.io_valid        = valid_reg;
    assign bus.io_change_valid = change_valid_reg;
    assign bus.io_busy         = busy_reg;
    assign bus.io_credit       = credit_reg;
endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed bench for vending_machine_gen: default PRICE=4 instance plus a PRICE=7/CREDIT_W=4 instance.
// Inputs change 1 ns after a rising edge; registered outputs are checked there too.
module tb_vending_machine_gen;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    vending_machine_gen_if #(.CREDIT_W(5)) bus_a ();
    vending_machine_gen_if #(.CREDIT_W(4)) bus_b ();

    vending_machine_gen #(.PRICE(4), .CREDIT_W(5)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    vending_machine_gen #(.PRICE(7), .CREDIT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic n, input logic d, input logic q, input logic c, input logic r);
        bus_a.io_nickel       = n;
        bus_a.io_dime         = d;
        bus_a.io_quarter      = q;
        bus_a.io_cancel       = c;
        bus_a.io_change_ready = r;
    endtask

    task automatic drive_b(input logic n, input logic d, input logic q, input logic c, input logic r);
        bus_b.io_nickel       = n;
        bus_b.io_dime         = d;
        bus_b.io_quarter      = q;
        bus_b.io_cancel       = c;
        bus_b.io_change_ready = r;
    endtask

    task automatic chk_a(input string tag, input int credit, input logic valid,
                         input logic cvalid, input logic busy);
        chk({tag, ".credit"}, 32'(bus_a.io_credit), 32'(credit));
        chk({tag, ".valid"},  32'(bus_a.io_valid), 32'(valid));
        chk({tag, ".cvalid"}, 32'(bus_a.io_change_valid), 32'(cvalid));
        chk({tag, ".busy"},   32'(bus_a.io_busy), 32'(busy));
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        #2;
        chk_a("rst_held", 0, 0, 0, 0);
        chk("rst_held.reject", 32'(bus_a.io_coin_reject), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        chk_a("rst_release", 0, 0, 0, 0);
        chk("rst_release.b_credit", 32'(bus_b.io_credit), 32'd0);
        tick();
        chk_a("first_cycle", 0, 0, 0, 0);

        // Four nickels: credit 1,2,3 then dispense, no change
        drive_a(1, 0, 0, 0, 0);
        tick(); chk_a("n4.c1", 1, 0, 0, 0);
        tick(); chk_a("n4.c2", 2, 0, 0, 0);
        tick(); chk_a("n4.c3", 3, 0, 0, 0);
        tick(); chk_a("n4.vend", 4, 1, 0, 1);
        drive_a(0, 0, 0, 0, 0);
        tick(); chk_a("n4.idle", 0, 0, 0, 0);
        tick(); chk_a("n4.stay", 0, 0, 0, 0);

        // n,n,n,d: 5 credit, one nickel change
        drive_a(1, 0, 0, 0, 0);
        tick(); tick(); tick(); chk_a("nnnd.c3", 3, 0, 0, 0);
        drive_a(0, 1, 0, 0, 0);
        tick(); chk_a("nnnd.vend", 5, 1, 0, 1);
        drive_a(0, 0, 0, 0, 0);
        tick(); chk_a("nnnd.change", 1, 0, 1, 1);
        drive_a(0, 0, 0, 0, 1);
        tick(); chk_a("nnnd.idle", 0, 0, 0, 0);
        drive_a(0, 0, 0, 0, 0);

        // Quarter with change stalled by ready=0
        drive_a(0, 0, 1, 0, 0);
        tick(); chk_a("q.vend", 5, 1, 0, 1);
        drive_a(0, 0, 0, 0, 0);
        tick(); chk_a("q.change", 1, 0, 1, 1);
        tick(); chk_a("q.stall1", 1, 0, 1, 1);
        tick(); chk_a("q.stall2", 1, 0, 1, 1);
        tick(); chk_a("q.stall3", 1, 0, 1, 1);
        drive_a(0, 0, 0, 0, 1);
        tick(); chk_a("q.idle", 0, 0, 0, 0);
        drive_a(0, 0, 0, 0, 0);

        // Double coin in COLLECT, then cancel beating a dime
        drive_a(1, 0, 0, 0, 0);
        #1 chk("dn.single_reject", 32'(bus_a.io_coin_reject), 32'd0);
        tick(); chk_a("dn.c1", 1, 0, 0, 0);
        drive_a(1, 1, 0, 0, 0);
        #1 chk("dn.reject", 32'(bus_a.io_coin_reject), 32'd1);
        tick(); chk_a("dn.c3", 3, 0, 0, 0);
        drive_a(0, 0, 0, 0, 0);
        #1 chk("dn.reject_clear", 32'(bus_a.io_coin_reject), 32'd0);
        drive_a(0, 1, 0, 1, 0);
        #1 chk("cancel.reject", 32'(bus_a.io_coin_reject), 32'd1);
        tick(); chk_a("cancel.change3", 3, 0, 1, 1);
        drive_a(0, 0, 0, 0, 1);
        tick(); chk_a("cancel.change2", 2, 0, 1, 1);
        tick(); chk_a("cancel.change1", 1, 0, 1, 1);
        tick(); chk_a("cancel.idle", 0, 0, 0, 0);
        drive_a(0, 0, 0, 0, 0);

        // Coins during VEND and CHANGE are refused
        drive_a(0, 1, 0, 0, 0);
        tick(); chk_a("busy.c2", 2, 0, 0, 0);
        drive_a(0, 0, 1, 0, 0);
        tick(); chk_a("busy.vend", 7, 1, 0, 1);
        drive_a(1, 0, 0, 0, 0);
        #1 chk("busy.vend_reject", 32'(bus_a.io_coin_reject), 32'd1);
        tick(); chk_a("busy.change3", 3, 0, 1, 1);
        drive_a(0, 1, 0, 0, 1);
        #1 chk("busy.change_reject", 32'(bus_a.io_coin_reject), 32'd1);
        tick(); chk_a("busy.change2", 2, 0, 1, 1);

        // Asynchronous reset mid-change, checked before any clock edge
        drive_a(0, 1, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        chk("async_rst.reject", 32'(bus_a.io_coin_reject), 32'd0);
        drive_a(0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        tick(); chk_a("async_rst.after", 0, 0, 0, 0);

        // PRICE=7, CREDIT_W=4: quarter then dime, exact price, no change
        drive_b(0, 0, 1, 0, 0);
        tick();
        chk("b.q.credit", 32'(bus_b.io_credit), 32'd5);
        chk("b.q.valid", 32'(bus_b.io_valid), 32'd0);
        drive_b(0, 1, 0, 0, 0);
        tick();
        chk("b.vend.credit", 32'(bus_b.io_credit), 32'd7);
        chk("b.vend.valid", 32'(bus_b.io_valid), 32'd1);
        drive_b(0, 0, 0, 0, 0);
        tick();
        chk("b.idle.credit", 32'(bus_b.io_credit), 32'd0);
        chk("b.idle.valid", 32'(bus_b.io_valid), 32'd0);
        chk("b.idle.cvalid", 32'(bus_b.io_change_valid), 32'd0);
        chk("b.idle.busy", 32'(bus_b.io_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
